// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader for the instruction memory.
// Holds the CPU in reset until a whole-word image has been written.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_wa,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     cpu_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, DATA = 3'd3, DONE = 3'd4, ERR = 3'd5;
  logic [2:0] state, state_nx;
  logic [15:0] len, offset, len_full;
  logic acc;
  assign busy = state == LEN_LO || state == LEN_HI || state == DATA;
  assign in_ready = busy;
  assign done = state == DONE;
  assign err = state == ERR;
  assign acc = in_valid && in_ready;
  assign len_full = {in_data[7:0], len[7:0]};
  // start only matters outside a load; an accepted byte always wins while busy
  always_comb begin
    state_nx = state;
    if (!busy && start)
      state_nx = LEN_LO;
    else if (acc)
      state_nx = state == LEN_LO ? LEN_HI :
                 state == LEN_HI ? (len_full[1:0] != 2'd0 ? ERR : len_full == 16'd0 ? DONE : DATA) :
                 offset == len - 16'd1 ? DONE : DATA;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      offset    <= '0;
      mem_we    <= 1'b0;
      mem_wa    <= '0;
      mem_wd    <= '0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_rst_n <= state == DONE && !start;
      mem_we    <= acc && state == DATA;
      if (acc && state == LEN_LO)
        len[7:0] <= in_data[7:0];
      if (acc && state == LEN_HI) begin
        len[15:8] <= in_data[7:0];
        offset    <= '0;
      end
      if (acc && state == DATA) begin
        offset <= offset + 16'd1;
        mem_wa <= BASE_ADDR + ADDRESS_WIDTH'(offset);
        mem_wd <= in_data;
      end
    end
  end
endmodule
